bht_resolve: RTL and testbench
==============================

# bht_resolve

Branch history table that consumes resolved branch outcomes from the execute stage and serves taken/not-taken predictions to the frontend. It closes the branch-prediction loop: each resolve record updates a 2-bit saturating counter, and the frontend queries the table by fetch PC. Table contents come from a sequential init engine after reset or a predictor flush.

## Interface
- NR_ENTRIES, 64, table depth; power of two, at least 4.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- flush_bp_i  in  1  re-initialise the whole table.
- debug_mode_i  in  1  when high, incoming updates are dropped.
- resolved_branch_i  in  ariane_pkg::bp_resolve_t  resolve record from the branch unit (valid, pc, cf_type.taken, is_mispredict used).
- is_cond_branch_i  in  1  qualifies resolved_branch_i as a conditional branch; driven by issue alongside the record.
- vpc_i  in  riscv::VLEN  fetch PC to look up.
- bht_prediction_o  out  ariane_pkg::bht_prediction_t  {valid, taken} for the vpc_i of the previous cycle.
- init_busy_o  out  1  table initialisation in progress.

## Operation
- Index = pc[$clog2(NR_ENTRIES):1]; bit 0 is ignored. Same rule for lookup and update.
- Entry = {valid, cnt[1:0]}. Predicted taken = cnt[1].
- FSM states:
  - INIT: idx_q walks 0..NR_ENTRIES-1, writing {0, 2'b01} once per cycle. Enter INIT on rst_i or flush_bp_i. After the last index, go to RUN.
  - RUN: normal lookup and update.
- A flush during INIT restarts idx_q at 0. In INIT, bht_prediction_o.valid=0 and updates are dropped.
- Update capture, stage U:
  - Capture when resolved_branch_i.valid && is_cond_branch_i && !debug_mode_i && state==RUN.
  - Register {index, taken = resolved_branch_i.cf_type.taken}.
  - A flush clears the pending U register.
- Apply, one cycle after capture:
  - Invalid entry becomes {1, taken ? 2'b10 : 2'b01}.
  - Valid entry: taken increments, saturating at 3; not-taken decrements, saturating at 0.
- Back-to-back updates to the same index: the second update reads the first update's result (forwarded), so no update is lost.
- Lookup: the registered output uses the table value after any write applied in the same cycle. An update apply to the looked-up index is bypassed.

## Timing
- Reset values:
  - bht_prediction_o = '0.
  - init_busy_o = 1.
  - state = INIT, idx_q = 0, U register invalid.
- Initialisation takes NR_ENTRIES cycles. With rst_i released before edge 0, init_busy_o falls after edge NR_ENTRIES-1 (64 cycles for the default).
- Lookup latency: 1 cycle.
- Update visibility:
  - Resolve at edge N is captured into U.
  - The table is written at edge N+1.
  - A lookup of that index presented in cycle N+1 already sees the new value.
- rst_i mid-operation: takes effect at the next edge and overrides flush and updates.

## Configuration
- BHT_STATS_EN defined:
  - Adds outputs upd_cnt_o[31:0] and mispred_cnt_o[31:0].
  - upd_cnt_o increments on every captured update. mispred_cnt_o increments when a captured update also has is_mispredict=1.
  - Both counters wrap at 2^32, clear on rst_i, and are unaffected by flush_bp_i.
- BHT_STATS_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- ariane_pkg holds:
  - bht_entry_t.
  - bht_prediction_t.
  - The saturating-update function, so the test bench can reuse the model.
- The state enum is local to the module.
- No sub-module; the table is a flop array, and the init walker is inline.

## Test plan
- Reset: hold rst_i 3 cycles, then release → init_busy_o stays 1 for exactly 64 cycles; every lookup during that window returns valid=0.
- First update: resolve pc=0x80000010 taken, then look up 0x80000010 → valid=1, taken=1, cnt=2. Look up 0x80000012 → valid=0 (different index).
- Saturation: apply 4 taken updates to 0x100 → cnt=3. Then 1 not-taken → taken=1 (cnt=2). 2 more not-taken → cnt=0, taken=0. A further not-taken leaves cnt=0.
- Back-to-back same index: resolves for pc=0x200 in consecutive cycles, not-taken then taken (entry started at cnt=2) → final cnt=2, no lost update. Same-cycle lookup of 0x200 returns the bypassed value.
- Filters: debug_mode_i=1, a non-conditional record, and an update arriving during INIT → the table is unchanged in each case.
- Flush mid-init: assert flush_bp_i at init cycle 30 → the walk restarts and init_busy_o stays high 64 more cycles. A pending U update at flush time is discarded.

Source files
------------

// File: rtl/ariane_pkg.sv
// Branch-prediction types and the 2-bit saturating counter update.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package ariane_pkg;

  typedef struct packed {
    logic taken;
  } cf_t;

  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic                   is_mispredict;
    cf_t                    cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  // Weakly not-taken; the valid bit keeps it from being reported until trained.
  localparam bht_entry_t BHT_INIT_ENTRY = '{valid: 1'b0, cnt: 2'b01};

  function automatic bht_entry_t bht_update(input bht_entry_t e, input logic taken);
    bht_entry_t r;
    r.valid = 1'b1;
    if (!e.valid) begin
      r.cnt = taken ? 2'b10 : 2'b01;
    end else if (taken) begin
      r.cnt = (e.cnt == 2'b11) ? 2'b11 : e.cnt + 2'd1;
    end else begin
      r.cnt = (e.cnt == 2'b00) ? 2'b00 : e.cnt - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv.sv
// Architectural constants shared by the frontend and branch-prediction blocks.
// Latency: none (constants only).
// Backpressure: not applicable.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_resolve.sv
// Branch history table trained by resolved conditional branches; BHT_STATS_EN adds update/mispredict counters.
// Latency: lookup 1 cycle; resolve captured at edge N, written at N+1 and bypassed to lookups in that cycle.
// Backpressure: none; updates during init, debug mode or flush are dropped.
module bht_resolve
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_bp_i,
  input  logic                   debug_mode_i,
  input  bp_resolve_t            resolved_branch_i,
  input  logic                   is_cond_branch_i,
  input  logic [riscv::VLEN-1:0] vpc_i,
  output bht_prediction_t        bht_prediction_o,
  output logic                   init_busy_o
`ifdef BHT_STATS_EN
  ,
  output logic [31:0]            upd_cnt_o,
  output logic [31:0]            mispred_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_busy_q, init_busy_d;
  logic             upd_vld_q, upd_vld_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_taken_q, upd_taken_d;
  bht_prediction_t  pred_q, pred_d;
  bht_entry_t       bht_q [NR_ENTRIES];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  bht_entry_t       wr_val;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] rs_idx;
  bht_entry_t       lk_entry;

  assign lk_idx = vpc_i[IDX_W:1];
  assign rs_idx = resolved_branch_i.pc[IDX_W:1];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_busy_d = init_busy_q;
    upd_vld_d   = 1'b0;
    upd_idx_d   = upd_idx_q;
    upd_taken_d = upd_taken_q;
    pred_d      = '0;
    wr_en       = 1'b0;
    wr_idx      = idx_q;
    wr_val      = BHT_INIT_ENTRY;
    lk_entry    = bht_q[lk_idx];

    if (flush_bp_i) begin
      state_d     = ST_INIT;
      idx_d       = '0;
      init_busy_d = 1'b1;
    end else if (state_q == ST_INIT) begin
      wr_en = 1'b1;
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_W'(NR_ENTRIES - 1)) begin
        state_d     = ST_RUN;
        init_busy_d = 1'b0;
      end
    end else begin
      // Reading the table in the apply cycle picks up the previous apply, so
      // back-to-back updates to one index chain without a separate forward path.
      if (upd_vld_q) begin
        wr_en  = 1'b1;
        wr_idx = upd_idx_q;
        wr_val = bht_update(bht_q[upd_idx_q], upd_taken_q);
      end
      if (wr_en && (wr_idx == lk_idx)) begin
        lk_entry = wr_val;
      end
      pred_d.valid = lk_entry.valid;
      pred_d.taken = lk_entry.cnt[1];
      if (resolved_branch_i.valid && is_cond_branch_i && !debug_mode_i) begin
        upd_vld_d   = 1'b1;
        upd_idx_d   = rs_idx;
        upd_taken_d = resolved_branch_i.cf_type.taken;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_busy_q <= 1'b1;
      upd_vld_q   <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      pred_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_busy_q <= init_busy_d;
      upd_vld_q   <= upd_vld_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
      pred_q      <= pred_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      bht_q[wr_idx] <= wr_val;
    end
  end

  assign bht_prediction_o = pred_q;
  assign init_busy_o      = init_busy_q;

`ifdef BHT_STATS_EN
  logic [31:0] upd_cnt_q, upd_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_vld_d) begin
      upd_cnt_d = upd_cnt_q + 32'd1;
      if (resolved_branch_i.is_mispredict) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      upd_cnt_q     <= upd_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign upd_cnt_o     = upd_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{vpc_i[riscv::VLEN-1:IDX_W+1], vpc_i[0],
                         resolved_branch_i.pc[riscv::VLEN-1:IDX_W+1],
                         resolved_branch_i.pc[0], resolved_branch_i.is_mispredict};

endmodule

// File: tb/tb_bht_resolve.sv
// Randomised and directed bench for bht_resolve against an array-based reference table.
// Latency: checks every cycle, 1 ns after the rising edge.
// Backpressure: not applicable.
module tb_bht_resolve;
  import ariane_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   flush;
  logic                   dbg;
  logic                   cond;
  bp_resolve_t            rb;
  logic [riscv::VLEN-1:0] vpc;
  bht_prediction_t        pred;
  logic                   busy;

  bht_resolve #(.NR_ENTRIES(N)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_bp_i       (flush),
    .debug_mode_i     (dbg),
    .resolved_branch_i(rb),
    .is_cond_branch_i (cond),
    .vpc_i            (vpc),
    .bht_prediction_o (pred),
    .init_busy_o      (busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference: per-index valid flag and integer counter, pending update, init countdown.
  bit         m_vld [N];
  int         m_cnt [N];
  int         m_left;
  bit         p_v;
  int         p_idx;
  bit         p_t;
  logic [1:0] m_pred;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int pidx(input logic [63:0] pc);
    return int'((pc >> 1) % N);
  endfunction

  task automatic model_edge();
    int li;
    li = pidx(vpc);
    if (rst || flush) begin
      m_left = N;
      p_v    = 1'b0;
      m_pred = 2'b00;
      for (int i = 0; i < N; i++) begin
        m_vld[i] = 1'b0;
        m_cnt[i] = 1;
      end
    end else if (m_left > 0) begin
      m_left--;
      m_pred = 2'b00;
    end else begin
      if (p_v) begin
        if (!m_vld[p_idx]) begin
          m_vld[p_idx] = 1'b1;
          m_cnt[p_idx] = p_t ? 2 : 1;
        end else if (p_t) begin
          m_cnt[p_idx] = (m_cnt[p_idx] >= 3) ? 3 : m_cnt[p_idx] + 1;
        end else begin
          m_cnt[p_idx] = (m_cnt[p_idx] <= 0) ? 0 : m_cnt[p_idx] - 1;
        end
      end
      m_pred = {m_vld[li], m_cnt[li] >= 2};
      p_v    = rb.valid && cond && !dbg;
      p_idx  = pidx(rb.pc);
      p_t    = rb.cf_type.taken;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("busy", 32'(busy), 32'(m_left > 0));
    check_eq("pred", 32'(pred), 32'(m_pred));
  endtask

  task automatic drive(input bit v, input logic [63:0] pc, input bit tk, input bit c,
                       input bit d, input logic [63:0] look);
    rb.valid         = v;
    rb.pc            = pc;
    rb.cf_type.taken = tk;
    rb.is_mispredict = 1'($urandom_range(0, 1));
    cond             = c;
    dbg              = d;
    vpc              = look;
    tick();
  endtask

  function automatic logic [63:0] rpc();
    return 64'h8000_0000 + (64'($urandom_range(0, 3)) << 7)
         + (64'($urandom_range(0, 7)) << 1) + 64'($urandom_range(0, 1));
  endfunction

  task automatic drive_rand();
    drive(1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), rpc());
  endtask

  int n;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    dbg   = 1'b0;
    cond  = 1'b0;
    rb    = '0;
    vpc   = '0;

    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_busy", 32'(busy), 32'h1);
    check_eq("rst_pred", 32'(pred), 32'h0);
    rst = 1'b0;

    // Updates offered during init must be dropped.
    n = 0;
    do begin
      drive(1'b1, rpc(), 1'b1, 1'b1, 1'b0, rpc());
      n++;
    end while (busy && n < 200);
    check_eq("init_len", 32'(n), 32'd64);

    drive(1'b1, 64'h8000_0010, 1'b1, 1'b1, 1'b0, 64'h8000_0010);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h8000_0010);
    check_eq("first_upd", 32'(pred), 32'h3);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h8000_0012);
    check_eq("other_idx", 32'(pred), 32'h0);

    for (int i = 0; i < 4; i++) drive(1'b1, 64'h100, 1'b1, 1'b1, 1'b0, 64'h100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h100);
    check_eq("sat_hi", 32'(pred), 32'h3);
    drive(1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 64'h100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h100);
    check_eq("dec_from_3", 32'(pred), 32'h3);
    for (int i = 0; i < 2; i++) drive(1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 64'h100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h100);
    check_eq("sat_lo", 32'(pred), 32'h2);
    drive(1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 64'h100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h100);
    check_eq("sat_lo_hold", 32'(pred), 32'h2);
    drive(1'b1, 64'h100, 1'b1, 1'b1, 1'b0, 64'h100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h100);
    check_eq("from_zero", 32'(pred), 32'h2);

    // 0x200 aliases 0x100 (index 0), currently cnt=1; one taken brings it to 2.
    drive(1'b1, 64'h200, 1'b1, 1'b1, 1'b0, 64'h200);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h200);
    check_eq("b2b_pre", 32'(pred), 32'h3);
    drive(1'b1, 64'h200, 1'b0, 1'b1, 1'b0, 64'h200);
    drive(1'b1, 64'h200, 1'b1, 1'b1, 1'b0, 64'h200);
    check_eq("b2b_byp1", 32'(pred), 32'h2);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h200);
    check_eq("b2b_byp2", 32'(pred), 32'h3);
    drive(1'b1, 64'h200, 1'b0, 1'b1, 1'b0, 64'h200);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h200);
    check_eq("b2b_nolost", 32'(pred), 32'h2);

    drive(1'b1, 64'h40, 1'b1, 1'b1, 1'b1, 64'h40);
    drive(1'b1, 64'h40, 1'b1, 1'b0, 1'b0, 64'h40);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h40);
    check_eq("filter", 32'(pred), 32'h0);

    // Capture an update, then flush while it is pending.
    drive(1'b1, 64'h40, 1'b1, 1'b1, 1'b0, 64'h40);
    flush = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h40);
    flush = 1'b0;
    for (int i = 0; i < 30; i++) drive(1'b1, 64'h40, 1'b1, 1'b1, 1'b0, 64'h40);
    flush = 1'b1;
    drive(1'b1, 64'h40, 1'b1, 1'b1, 1'b0, 64'h40);
    flush = 1'b0;
    n = 0;
    do begin
      drive(1'b1, 64'h40, 1'b1, 1'b1, 1'b0, 64'h40);
      n++;
    end while (busy && n < 200);
    check_eq("reinit_len", 32'(n), 32'd64);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h40);
    check_eq("flush_drop", 32'(pred), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      flush = ($urandom_range(0, 149) == 0);
      drive_rand();
    end
    rst   = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 80; i++) drive_rand();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
